// File: rtl/suma_pf_param.sv
// Multi-cycle floating-point adder/subtractor (IDLE/ALIGN/ADD/NORM/ROUND/DONE), subnormals flushed.
// Define SUMA_PF_RNE_EN for round-to-nearest-even; otherwise truncate toward zero with overflow saturation.
module suma_pf_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [2:0]           flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int FW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int SW  = FW + 1;             // plus adder carry
    localparam int LZW = $clog2(FW + 1);
    localparam int XW  = EXP_W + LZW + 1;    // two's-complement working exponent

    localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} stateT;
    stateT state, stateNext;

    // operand registers (B already carries the effective sign)
    logic [W-1:0] opA, opB;

    // ALIGN results
    logic [FW-1:0]    alBig, alSmall;
    logic [EXP_W-1:0] alExp;
    logic             alSign, alSub, alZeroSign, alSpecial;
    logic [W-1:0]     alSpecRes;
    logic [2:0]       alSpecFlags;

    // ADD / NORM results
    logic [SW-1:0]    sumR;
    logic [FW-1:0]    nmMan;
    logic [XW-1:0]    nmExp;
    logic             nmZero, nmUf;

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) stateNext = ALIGN;
            end
            ALIGN: stateNext = ADD;
            ADD:   stateNext = NORM;
            NORM:  stateNext = ROUND;
            ROUND: stateNext = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // ALIGN: unpack, classify, order by magnitude, shift smaller with G/R/S
    logic             sA, sB, nanA, nanB, infA, infB, zeroA, zeroB, aBig;
    logic [EXP_W-1:0] eA, eB, eBig, eSmall, expDiff;
    logic [MAN_W:0]   mA, mB, mBig, mSmall;
    logic [FW-1:0]    extSmall, shifted, alignedSmall;
    logic             lost, sBig;
    logic             specN;
    logic [W-1:0]     specResN;
    logic [2:0]       specFlagsN;

    assign sA    = opA[W-1];
    assign sB    = opB[W-1];
    assign eA    = opA[W-2:MAN_W];
    assign eB    = opB[W-2:MAN_W];
    assign nanA  = (&eA) && (|opA[MAN_W-1:0]);
    assign nanB  = (&eB) && (|opB[MAN_W-1:0]);
    assign infA  = (&eA) && !(|opA[MAN_W-1:0]);
    assign infB  = (&eB) && !(|opB[MAN_W-1:0]);
    assign zeroA = !(|eA);
    assign zeroB = !(|eB);
    assign mA    = zeroA ? '0 : {1'b1, opA[MAN_W-1:0]};
    assign mB    = zeroB ? '0 : {1'b1, opB[MAN_W-1:0]};
    assign aBig  = {eA, mA} >= {eB, mB};

    assign eBig     = aBig ? eA : eB;
    assign eSmall   = aBig ? eB : eA;
    assign mBig     = aBig ? mA : mB;
    assign mSmall   = aBig ? mB : mA;
    assign sBig     = aBig ? sA : sB;
    assign expDiff  = eBig - eSmall;
    assign extSmall = {mSmall, 3'b000};
    assign shifted  = extSmall >> expDiff;
    assign lost     = (shifted << expDiff) != extSmall;

    always_comb begin
        if (32'(expDiff) > MAN_W + 3)
            alignedSmall = {{(FW-1){1'b0}}, |mSmall};
        else
            alignedSmall = {shifted[FW-1:1], shifted[0] | lost};
    end

    always_comb begin
        specN      = 1'b1;
        specResN   = QNAN;
        specFlagsN = 3'b000;
        if (nanA || nanB) begin
            specResN = QNAN;
        end else if (infA && infB && (sA != sB)) begin
            specFlagsN = 3'b100;
        end else if (infA) begin
            specResN = {sA, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (infB) begin
            specResN = {sB, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            specN = 1'b0;
        end
    end

    // NORM: carry right-shift or leading-zero left-shift in one step
    logic [LZW-1:0] lzc;
    logic           found;
    logic [FW-1:0]  normShift;
    logic [XW-1:0]  expExt, expDec;

    always_comb begin
        lzc   = '0;
        found = 1'b0;
        for (int i = FW - 1; i >= 0; i--) begin
            if (!found) begin
                if (sumR[i]) found = 1'b1;
                else         lzc   = lzc + LZW'(1);
            end
        end
    end

    assign normShift = sumR[FW-1:0] << lzc;
    assign expExt    = {{(XW-EXP_W){1'b0}}, alExp};
    assign expDec    = expExt - {{(XW-LZW){1'b0}}, lzc};

    // ROUND
    logic           inc, inexact;
    logic [MAN_W+1:0] rnd;
    logic [XW-1:0]  rExp;
    logic [W-1:0]   ovfRes, resN;
    logic [2:0]     flN;

`ifdef SUMA_PF_RNE_EN
    assign inc    = nmMan[2] & (nmMan[1] | nmMan[0] | nmMan[3]);
    assign ovfRes = {alSign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
    assign inc    = 1'b0;
    assign ovfRes = {alSign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif

    assign inexact = |nmMan[2:0];
    assign rnd     = {1'b0, nmMan[FW-1:3]} + (MAN_W+2)'(inc);
    // a rounding carry leaves the fraction bits at zero, so only the exponent moves
    assign rExp    = nmExp + XW'(rnd[MAN_W+1]);

    always_comb begin
        resN = {alSign, rExp[EXP_W-1:0], rnd[MAN_W-1:0]};
        flN  = {2'b00, inexact};
        if (alSpecial) begin
            resN = alSpecRes;
            flN  = alSpecFlags;
        end else if (nmZero) begin
            resN = {alZeroSign, {(W-1){1'b0}}};
            flN  = 3'b000;
        end else if (nmUf) begin
            resN = {alSign, {(W-1){1'b0}}};
            flN  = 3'b001;
        end else if (rExp >= EXP_MAX) begin
            resN = ovfRes;
            flN  = 3'b011;
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA         <= '0;
            opB         <= '0;
            alBig       <= '0;
            alSmall     <= '0;
            alExp       <= '0;
            alSign      <= 1'b0;
            alSub       <= 1'b0;
            alZeroSign  <= 1'b0;
            alSpecial   <= 1'b0;
            alSpecRes   <= '0;
            alSpecFlags <= '0;
            sumR        <= '0;
            nmMan       <= '0;
            nmExp       <= '0;
            nmZero      <= 1'b0;
            nmUf        <= 1'b0;
            result      <= '0;
            flags       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    opA <= a;
                    opB <= {b[W-1] ^ sub, b[W-2:0]};
                end
                ALIGN: begin
                    alBig       <= {mBig, 3'b000};
                    alSmall     <= alignedSmall;
                    alExp       <= eBig;
                    alSign      <= sBig;
                    alSub       <= sA ^ sB;
                    alZeroSign  <= zeroA & zeroB & sA & sB;
                    alSpecial   <= specN;
                    alSpecRes   <= specResN;
                    alSpecFlags <= specFlagsN;
                end
                ADD: begin
                    if (alSub) sumR <= {1'b0, alBig} - {1'b0, alSmall};
                    else       sumR <= {1'b0, alBig} + {1'b0, alSmall};
                end
                NORM: begin
                    nmZero <= 1'b0;
                    nmUf   <= 1'b0;
                    if (sumR[SW-1]) begin
                        nmMan <= {sumR[SW-1:2], sumR[1] | sumR[0]};
                        nmExp <= expExt + XW'(1);
                    end else if (sumR == '0) begin
                        nmMan  <= '0;
                        nmExp  <= '0;
                        nmZero <= 1'b1;
                    end else begin
                        nmMan <= normShift;
                        nmExp <= expDec;
                        nmUf  <= expDec[XW-1] || (expDec == '0);
                    end
                end
                ROUND: begin
                    result <= resN;
                    flags  <= flN;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_suma_pf_param.sv
// Bench for suma_pf_param (binary32): directed vector table, handshake/reset sequences,
// and random operations against an exact-integer reference model.
module tb_suma_pf_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [2:0]  flags;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    suma_pf_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [2:0]  fl;
    } vecT;
    vecT vecs[$];

    task automatic addVec(input logic [31:0] va, vb, input logic vs, input logic [31:0] vr, input logic [2:0] vf);
        vecT v;
        v.a = va; v.b = vb; v.sub = vs; v.res = vr; v.fl = vf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one full transaction; lat counts edges from accept to out_valid
    task automatic doOp(input logic [31:0] ia, ib, input logic isub,
                        output logic [31:0] r, output logic [2:0] f, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        a = ia; b = ib; sub = isub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        r = result; f = flags;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // exact reference: align both magnitudes onto a common integer grid, add, then round once
    function automatic logic [34:0] refModel(input logic [31:0] ra, rb, input logic rsub);
        logic sa, sb, s, sHi, sLo;
        int ea, eb, eHi, eLo, diff, sh, base, p, e, k;
        logic [127:0] ma, mb, hiI, loI, v, q, rem, half;
        sa = ra[31]; sb = rb[31] ^ rsub;
        ea = int'(ra[30:23]); eb = int'(rb[30:23]);
        if ((ea == 255 && ra[22:0] != 0) || (eb == 255 && rb[22:0] != 0))
            return {3'b000, 32'h7FC00000};
        if (ea == 255 && eb == 255)
            return (sa != sb) ? {3'b100, 32'h7FC00000} : {3'b000, sa, 8'hFF, 23'h0};
        if (ea == 255) return {3'b000, sa, 8'hFF, 23'h0};
        if (eb == 255) return {3'b000, sb, 8'hFF, 23'h0};
        ma = (ea == 0) ? 128'h0 : (128'h800000 | 128'(ra[22:0]));
        mb = (eb == 0) ? 128'h0 : (128'h800000 | 128'(rb[22:0]));
        if (ma == 0 && mb == 0) return {3'b000, sa & sb, 31'h0};
        if (ea >= eb) begin eHi = ea; eLo = eb; hiI = ma; loI = mb; sHi = sa; sLo = sb; end
        else          begin eHi = eb; eLo = ea; hiI = mb; loI = ma; sHi = sb; sLo = sa; end
        diff = eHi - eLo;
        sh   = (diff > 60) ? 60 : diff;
        base = eHi - sh;
        hiI  = hiI << sh;
        if (diff > 60) loI = (loI != 0) ? 128'h1 : 128'h0;
        if (sHi == sLo) begin v = hiI + loI; s = sHi; end
        else if (hiI > loI) begin v = hiI - loI; s = sHi; end
        else if (loI > hiI) begin v = loI - hiI; s = sLo; end
        else return {3'b000, 32'h0};
        p = 0;
        for (int i = 0; i < 128; i++) if (v[i]) p = i;
        e = base + p - 23;
        if (e <= 0) return {3'b001, s, 31'h0};
        if (p >= 23) begin
            k = p - 23;
            q = v >> k;
            rem = v & ((128'h1 << k) - 1);
        end else begin
            k = 0;
            q = v << (23 - p);
            rem = 0;
        end
`ifdef SUMA_PF_RNE_EN
        if (k > 0) begin
            half = 128'h1 << (k - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
        if (q[24]) begin q = q >> 1; e = e + 1; end
        if (e >= 255) return {3'b011, s, 8'hFF, 23'h0};
`else
        half = 0;
        if (e >= 255) return {3'b011, s, 8'hFE, 23'h7FFFFF};
`endif
        return {2'b00, rem != 0, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rndOp(input int refE);
        int k, t;
        logic [7:0]  e;
        logic [22:0] f;
        k = int'($urandom_range(0, 15));
        f = 23'($urandom);
        if (k == 0)      e = 8'h00;
        else if (k == 1) begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
        else if (k <= 3) e = 8'($urandom_range(248, 254));
        else if (k <= 10) begin
            t = refE + int'($urandom_range(0, 60)) - 30;
            if (t < 1) t = 1;
            if (t > 254) t = 254;
            e = 8'(t);
        end else e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, f};
    endfunction

    initial begin
        logic [31:0] r, r0, ra, rb;
        logic [2:0]  f, f0;
        logic [34:0] m;
        logic        rs;
        int          lat, n, bad;

        // reset state
        repeat (2) @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset flags", 64'(flags), 64'd0);
        rst_n = 1'b1;

        addVec(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        addVec(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
`ifdef SUMA_PF_RNE_EN
        addVec(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001);
        addVec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        addVec(32'h3F800000, 32'h00800000, 1'b1, 32'h3F800000, 3'b001);
`else
        addVec(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 3'b001);
        addVec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 3'b011);
        addVec(32'h3F800000, 32'h00800000, 1'b1, 32'h3F7FFFFF, 3'b001);
`endif
        addVec(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        addVec(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
        addVec(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        addVec(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b001);
        addVec(32'h7F800000, 32'hBF800000, 1'b0, 32'h7F800000, 3'b000);
        addVec(32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b000);
        addVec(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001);
        addVec(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
        addVec(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);

        foreach (vecs[i]) begin
            doOp(vecs[i].a, vecs[i].b, vecs[i].sub, r, f, lat);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d result", i), 64'(r), 64'(vecs[i].res));
            chk($sformatf("vec%0d flags", i), 64'(f), 64'(vecs[i].fl));
        end

        // backpressure: hold DONE for 5 cycles while a new request waits
        @(negedge clk);
        a = 32'h40400000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F800000;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("hold latency", 64'(n), 64'd4);
        r0 = result; f0 = flags;
        chk("hold value", 64'(r0), 64'h40800000);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (result !== r0 || flags !== f0 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        chk("hold stable", 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        // in_valid still high: accepted on the edge after the handshake
        @(negedge clk);
        chk("next op in ALIGN", 64'({in_ready, out_valid}), 64'd0);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("midop reset out_valid", 64'(out_valid), 64'd0);
        chk("midop reset in_ready", 64'(in_ready), 64'd1);
        chk("midop reset result", 64'({flags, result}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || result !== 32'h0) bad++;
        end
        chk("no stale output", 64'(bad), 64'd0);

        // first accept on the first rising edge after reset release
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("post-reset latency", 64'(n), 64'd4);
        chk("post-reset result", 64'(result), 64'h40400000);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // randomized against the reference model
        for (int i = 0; i < 400; i++) begin
            ra = rndOp(int'($urandom_range(1, 254)));
            if ($urandom_range(0, 15) == 0) rb = {1'($urandom), ra[30:0]};
            else rb = rndOp(int'(ra[30:23]));
            rs = 1'($urandom);
            m = refModel(ra, rb, rs);
            doOp(ra, rb, rs, r, f, lat);
            chk($sformatf("rand %h %s %h", ra, rs ? "-" : "+", rb),
                64'({lat[7:0], f, r}), 64'({8'd4, m}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
